// File: rtl/note_sequencer_pkg.sv
// Shared widths, sizes and FSM encoding for the note sequencer.
package note_sequencer_pkg;

  localparam int STEP_BW_DEF   = 24;
  localparam int GAP_BW_DEF    = 16;
  localparam int IDX_BW_DEF    = 6;
  localparam int NUM_NOTES_DEF = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/note_sequencer_step_timer.sv
// Per-note tick counter: reports the last tick of a note and whether the
// current tick lies inside the silent articulation gap at the end of the note.
module note_sequencer_step_timer #(
  parameter int STEP_BW = 24,
  parameter int GAP_BW  = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [STEP_BW-1:0] step_reg_i,
  input  logic [GAP_BW-1:0]  gap_reg_i,
  output logic               boundary_o,
  output logic               in_gap_o
);

  logic [STEP_BW-1:0] tick_cnt_q, tick_cnt_d;
  logic               last_tick_s;
  logic [STEP_BW:0]   tick_plus_gap_s;

  assign last_tick_s = (tick_cnt_q == (step_reg_i - STEP_BW'(1)));
  assign boundary_o  = en_i & last_tick_s;

  // tick + gap >= step is tick >= step - gap without the subtraction underflowing
  assign tick_plus_gap_s = {1'b0, tick_cnt_q} + (STEP_BW + 1)'(gap_reg_i);
  assign in_gap_o        = (tick_plus_gap_s >= {1'b0, step_reg_i});

  // Next tick count: clear wins, otherwise count and wrap on the last tick of a note.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear_i) begin
      tick_cnt_d = '0;
    end else if (en_i) begin
      if (last_tick_s) begin
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + STEP_BW'(1);
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Tick counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps the melody ROM index at a programmable tempo and gates
// the tone so that consecutive identical notes are heard separately.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int STEP_BW   = STEP_BW_DEF,
  parameter int GAP_BW    = GAP_BW_DEF,
  parameter int IDX_BW    = IDX_BW_DEF,
  parameter int NUM_NOTES = NUM_NOTES_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  input  logic [STEP_BW-1:0] stepTicks_i,
  input  logic [GAP_BW-1:0]  gapTicks_i,
  output logic [IDX_BW-1:0]  noteIndex_o,
  output logic               gate_o,
  output logic               step_o,
  output logic               playing_o,
  output logic               done_o
);

  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_NOTES - 1);

  state_e             state_q, state_d;
  logic [IDX_BW-1:0]  idx_q, idx_d;
  logic [STEP_BW-1:0] step_reg_q, step_reg_d;
  logic [GAP_BW-1:0]  gap_reg_q, gap_reg_d;
  logic               step_pulse_q, step_pulse_d;
  logic               done_q, done_d;

  logic               timer_clear_s, timer_en_s;
  logic               boundary_s, in_gap_s;
  logic [STEP_BW-1:0] step_in_s;

  // A zero tempo would never reach a boundary, so it plays as one tick per note.
  assign step_in_s = (stepTicks_i == '0) ? STEP_BW'(1) : stepTicks_i;

  note_sequencer_step_timer #(
    .STEP_BW (STEP_BW),
    .GAP_BW  (GAP_BW)
  ) u_step_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (timer_clear_s),
    .en_i       (timer_en_s),
    .step_reg_i (step_reg_q),
    .gap_reg_i  (gap_reg_q),
    .boundary_o (boundary_s),
    .in_gap_o   (in_gap_s)
  );

  // FSM next state, index stepping, tempo latching and pulse generation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    step_reg_d    = step_reg_q;
    gap_reg_d     = gap_reg_q;
    step_pulse_d  = 1'b0;
    done_d        = 1'b0;
    timer_clear_s = 1'b0;
    timer_en_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_clear_s = 1'b1;
        if (start_i && !stop_i) begin
          state_d      = S_PLAY;
          idx_d        = '0;
          step_reg_d   = step_in_s;
          gap_reg_d    = gapTicks_i;
          step_pulse_d = 1'b1;
        end else begin
          idx_d = '0;
        end
      end
      S_PLAY: begin
        if (stop_i) begin
          state_d       = S_IDLE;
          idx_d         = '0;
          timer_clear_s = 1'b1;
        end else if (start_i) begin
          idx_d         = '0;
          step_reg_d    = step_in_s;
          gap_reg_d     = gapTicks_i;
          step_pulse_d  = 1'b1;
          timer_clear_s = 1'b1;
        end else begin
          timer_en_s = 1'b1;
          if (boundary_s) begin
            step_reg_d = step_in_s;
            gap_reg_d  = gapTicks_i;
            if (idx_q == LAST_IDX) begin
              if (loop_i) begin
                idx_d        = '0;
                step_pulse_d = 1'b1;
              end else begin
                state_d = S_IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
              end
            end else begin
              idx_d        = idx_q + IDX_BW'(1);
              step_pulse_d = 1'b1;
            end
          end else begin
            idx_d = idx_q;
          end
        end
      end
      default: begin
        state_d       = S_IDLE;
        idx_d         = '0;
        timer_clear_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      step_reg_q   <= '0;
      gap_reg_q    <= '0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      step_reg_q   <= step_reg_d;
      gap_reg_q    <= gap_reg_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
    end
  end

  assign playing_o   = (state_q == S_PLAY);
  assign gate_o      = playing_o & ~in_gap_s;
  assign noteIndex_o = idx_q;
  assign step_o      = step_pulse_q;
  assign done_o      = done_q;

endmodule
